// File: rtl/w0rm_dbg_pkg.sv
// Shared constants for the W0RM bus debug master: opcodes, status bytes, FSM encoding.
package w0rm_dbg_pkg;

  localparam logic [7:0] OP_READ     = 8'h52;
  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] STS_ACK     = 8'h06;
  localparam logic [7:0] STS_TIMEOUT = 8'h15;
  localparam logic [7:0] STS_BADOP   = 8'h3F;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_DATA      = 3'd2,
    ST_REQ       = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT      = 3'd5,
    ST_RESP_HDR  = 3'd6,
    ST_RESP_DATA = 3'd7
  } state_e;

  // Status byte reported when WAIT ends, either by a response or by expiry.
  function automatic logic [7:0] wait_status(input logic timed_out);
    return timed_out ? STS_TIMEOUT : STS_ACK;
  endfunction

endpackage

// File: rtl/w0rm_dbg_byte_serializer.sv
// Loads up to NBYTES bytes and emits them MSB first; data/valid hold while tx_ready_i is low.
module w0rm_dbg_byte_serializer #(
  parameter int  NBYTES = 5,
  localparam int LEN_W  = $clog2(NBYTES + 1)
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset_n,
  input  logic                  load_i,
  input  logic [8*NBYTES-1:0]   word_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  last_o
);

  logic [8*NBYTES-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]    rem_q, rem_d;

  always_comb begin
    shift_d = shift_q;
    rem_d   = rem_q;
    if (load_i && (rem_q == '0)) begin
      shift_d = word_i;
      rem_d   = len_i;
    end else if ((rem_q != '0) && tx_ready_i) begin
      shift_d = shift_q << 8;
      rem_d   = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      shift_q <= '0;
      rem_q   <= '0;
    end else begin
      shift_q <= shift_d;
      rem_q   <= rem_d;
    end
  end

  assign tx_data_o  = shift_q[8*NBYTES-1 -: 8];
  assign tx_valid_o = (rem_q != '0);
  assign last_o     = (rem_q == LEN_W'(1));

endmodule

// File: rtl/w0rm_bus_debug_master.sv
// Byte-stream command decoder that issues single W0RM bus transactions and reports status/data on tx.
// Define W0RM_DBG_TIMEOUT_EN to bound the response wait to TIMEOUT_CYCLES cycles.
module w0rm_bus_debug_master
  import w0rm_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
`ifdef W0RM_DBG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset_n,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  bus_req_o,
  input  logic                  bus_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_valid_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_valid_i,
  output logic                  busy_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int NA    = ADDR_WIDTH / 8;
  localparam int MAXB  = (NA > NB) ? NA : NB;
  localparam int CNT_W = $clog2(MAXB + 1);
  localparam int SER_N = NB + 1;
  localparam int LEN_W = $clog2(SER_N + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    ser_load;
  logic [8*SER_N-1:0]      ser_word;
  logic [LEN_W-1:0]        ser_len;
  logic                    tx_last;
  logic                    rx_fire, tx_fire, own;
  logic [DATA_WIDTH-1:0]   rdata;
`ifdef W0RM_DBG_TIMEOUT_EN
  logic [15:0]             tmo_q, tmo_d;
`endif

  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign rdata   = is_wr_q ? {DATA_WIDTH{1'b0}} : mem_data_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    ser_load = 1'b0;
    ser_word = '0;
    ser_len  = '0;
`ifdef W0RM_DBG_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      ST_IDLE: if (rx_fire) begin
        if ((rx_data_i == OP_READ) || (rx_data_i == OP_WRITE)) begin
          is_wr_d = (rx_data_i == OP_WRITE);
          cnt_d   = '0;
          state_d = ST_ADDR;
        end else begin
          ser_load = 1'b1;
          ser_word = {STS_BADOP, {DATA_WIDTH{1'b0}}};
          ser_len  = LEN_W'(1);
          state_d  = ST_RESP_HDR;
        end
      end
      ST_ADDR: if (rx_fire) begin
        addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data_i);
        if (cnt_q == CNT_W'(NA - 1)) begin
          cnt_d   = '0;
          state_d = is_wr_q ? ST_DATA : ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: if (rx_fire) begin
        wdata_d = (wdata_q << 8) | DATA_WIDTH'(rx_data_i);
        if (cnt_q == CNT_W'(NB - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: if (bus_gnt_i) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef W0RM_DBG_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT: begin
        // A response in the expiry cycle still counts as a response.
        if (mem_valid_i) begin
          ser_load = 1'b1;
          ser_word = {wait_status(1'b0), rdata};
          ser_len  = is_wr_q ? LEN_W'(1) : LEN_W'(SER_N);
          state_d  = ST_RESP_HDR;
        end
`ifdef W0RM_DBG_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          ser_load = 1'b1;
          ser_word = {wait_status(1'b1), {DATA_WIDTH{1'b0}}};
          ser_len  = LEN_W'(1);
          state_d  = ST_RESP_HDR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`else
        else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_RESP_HDR: if (tx_fire) state_d = tx_last ? ST_IDLE : ST_RESP_DATA;
      ST_RESP_DATA: if (tx_fire && tx_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
  end

  // rx_ready is registered so it reads 0 while reset is held.
  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rx_ready_q <= 1'b0;
`ifdef W0RM_DBG_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      rx_ready_q <= rx_ready_d;
`ifdef W0RM_DBG_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  w0rm_dbg_byte_serializer #(.NBYTES(SER_N)) u_ser (
    .mem_clk     (mem_clk),
    .cpu_reset_n (cpu_reset_n),
    .load_i      (ser_load),
    .word_i      (ser_word),
    .len_i       (ser_len),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .last_o      (tx_last)
  );

  assign rx_ready_o  = rx_ready_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign bus_req_o   = (state_q == ST_REQ) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign own         = bus_req_o && bus_gnt_i;
  assign mem_valid_o = (state_q == ST_ISSUE) && bus_gnt_i;
  assign mem_read_o  = mem_valid_o && !is_wr_q;
  assign mem_write_o = mem_valid_o && is_wr_q;
  assign mem_addr_o  = own ? addr_q : '0;
  assign mem_data_o  = own ? wdata_q : '0;

endmodule

// File: tb/tb_w0rm_bus_debug_master.sv
// Directed bench for w0rm_bus_debug_master with a RAM/GPIO responder model on the bus.
module tb_w0rm_bus_debug_master;

  logic        mem_clk = 1'b0;
  logic        cpu_reset_n;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        mem_valid_o;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic        resp_en;
  logic        resp_valid_q;
  logic        late_valid;
  logic [7:0]  gpio_pins;
  logic [31:0] ram [0:15];
  logic [7:0]  got [$];

  int          cyc, n_pulse, n_req;
  logic [31:0] last_addr, last_data;
  logic        last_rd, last_wr;

  always #5 mem_clk = ~mem_clk;

  assign mem_valid_i = resp_valid_q | late_valid;

  w0rm_bus_debug_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
`ifdef W0RM_DBG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .mem_clk     (mem_clk),
    .cpu_reset_n (cpu_reset_n),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .bus_req_o   (bus_req_o),
    .bus_gnt_i   (bus_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_valid_o (mem_valid_o),
    .mem_data_i  (mem_data_i),
    .mem_valid_i (mem_valid_i),
    .busy_o      (busy_o)
  );

  // One-cycle responder: RAM below 0x80000000, GPIO pins above.
  always @(posedge mem_clk) begin
    resp_valid_q <= 1'b0;
    if (resp_en && mem_valid_o) begin
      resp_valid_q <= 1'b1;
      if (mem_write_o) begin
        ram[mem_addr_o[5:2]] <= mem_data_o;
        mem_data_i <= '0;
      end else begin
        mem_data_i <= mem_addr_o[31] ? {24'h0, gpio_pins} : ram[mem_addr_o[5:2]];
      end
    end
  end

  always @(posedge mem_clk) begin
    cyc <= cyc + 1;
    if (bus_req_o) n_req <= n_req + 1;
    if (mem_valid_o) begin
      n_pulse   <= n_pulse + 1;
      last_addr <= mem_addr_o;
      last_data <= mem_data_o;
      last_rd   <= mem_read_o;
      last_wr   <= mem_write_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge mem_clk);
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      if (rx_ready_o) begin
        @(posedge mem_clk);
        #1 rx_valid_i = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      rx_valid_i = 1'b0;
      $display("FAIL rx_accept: byte %02h never accepted, required acceptance within 100 cycles", b);
    end
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  // Collects n tx bytes; with rnd the ready line toggles and stalled bytes must hold.
  task automatic recv(input int n, input bit rnd);
    bit         held_v = 1'b0;
    logic [7:0] held_d = 8'h00;
    got.delete();
    for (int i = 0; i < 400 && got.size() < n; i++) begin
      @(negedge mem_clk);
      if (held_v) begin
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== held_d)
          $display("FAIL tx_hold: valid=%b data=%02h, required valid=1 data=%02h", tx_valid_o, tx_data_o, held_d);
        else n_pass++;
      end
      tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held_v = 1'b0;
      if (tx_valid_o) begin
        if (tx_ready_i) got.push_back(tx_data_o);
        else begin
          held_v = 1'b1;
          held_d = tx_data_o;
        end
      end
    end
    @(posedge mem_clk);
    #1 tx_ready_i = 1'b0;
    n_checks++;
    if (got.size() != n) $display("FAIL tx_count: got %0d bytes, required %0d", got.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset;
    cpu_reset_n = 1'b0;
    repeat (3) @(negedge mem_clk);
    n_checks++;
    if ({rx_ready_o, tx_valid_o, bus_req_o, busy_o, mem_valid_o} !== 5'b0)
      $display("FAIL reset_flags: rdy/txv/req/busy/mv=%b, required 00000", {rx_ready_o, tx_valid_o, bus_req_o, busy_o, mem_valid_o});
    else n_pass++;
    n_checks++;
    if (tx_data_o !== 8'h00 || mem_addr_o !== 32'h0)
      $display("FAIL reset_data: tx=%02h addr=%08h, required 00/00000000", tx_data_o, mem_addr_o);
    else n_pass++;
    cpu_reset_n = 1'b1;
    @(negedge mem_clk);
    n_checks++;
    if (rx_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL reset_release: rdy=%b busy=%b, required 1/0", rx_ready_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_write;
    int p0 = n_pulse;
    int issue_k = -1;
    int txv_k = -1;
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    for (int k = 1; k <= 8; k++) begin
      @(negedge mem_clk);
      if (mem_valid_o && issue_k < 0) issue_k = k;
      if (tx_valid_o && txv_k < 0) txv_k = k;
    end
    n_checks++;
    if (issue_k != 2 || txv_k != 4)
      $display("FAIL write_latency: issue +%0d tx_valid +%0d, required +2/+4", issue_k, txv_k);
    else n_pass++;
    n_checks++;
    if (n_pulse - p0 != 1 || last_wr !== 1'b1 || last_rd !== 1'b0)
      $display("FAIL write_pulse: pulses=%0d wr=%b rd=%b, required 1/1/0", n_pulse - p0, last_wr, last_rd);
    else n_pass++;
    n_checks++;
    if (last_addr !== 32'h10 || last_data !== 32'hDEADBEEF)
      $display("FAIL write_bus: addr=%08h data=%08h, required 00000010/deadbeef", last_addr, last_data);
    else n_pass++;
    recv(1, 1'b0);
    n_checks++;
    if (got[0] !== 8'h06) $display("FAIL write_status: got %02h, required 06", got[0]);
    else n_pass++;
    $display("write 0x10 <- deadbeef done");
  endtask

  task automatic test_read;
    logic [7:0] exp_ram [5];
    logic [7:0] exp_gpio [5];
    exp_ram  = '{8'h06, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_gpio = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h5A};
    send_read(32'h0000_0010);
    recv(5, 1'b0);
    n_checks++;
    if (last_rd !== 1'b1 || last_wr !== 1'b0 || last_addr !== 32'h10)
      $display("FAIL read_bus: rd=%b wr=%b addr=%08h, required 1/0/00000010", last_rd, last_wr, last_addr);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got[i] !== exp_ram[i]) $display("FAIL read_ram_byte%0d: got %02h, required %02h", i, got[i], exp_ram[i]);
      else n_pass++;
    end
    $display("read 0x10 done");
    send_read(32'h8000_0080);
    recv(5, 1'b0);
    n_checks++;
    if (last_addr !== 32'h8000_0080) $display("FAIL read_gpio_addr: got %08h, required 80000080", last_addr);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got[i] !== exp_gpio[i]) $display("FAIL read_gpio_byte%0d: got %02h, required %02h", i, got[i], exp_gpio[i]);
      else n_pass++;
    end
    $display("read gpio 0x80000080 done");
  endtask

  task automatic test_bad_opcode;
    int p0 = n_pulse;
    int r0 = n_req;
    send_byte(8'h41);
    recv(1, 1'b0);
    n_checks++;
    if (got[0] !== 8'h3F) $display("FAIL badop_status: got %02h, required 3f", got[0]);
    else n_pass++;
    n_checks++;
    if (n_pulse != p0 || n_req != r0)
      $display("FAIL badop_bus: pulses=%0d req_cycles=%0d, required 0/0", n_pulse - p0, n_req - r0);
    else n_pass++;
    send_read(32'h0000_0010);
    recv(5, 1'b0);
    n_checks++;
    if ({got[1], got[2], got[3], got[4]} !== 32'hDEADBEEF || got[0] !== 8'h06)
      $display("FAIL badop_recover: got %02h %02h%02h%02h%02h, required 06 deadbeef", got[0], got[1], got[2], got[3], got[4]);
    else n_pass++;
    $display("bad opcode 0x41 then read done");
  endtask

  task automatic test_gnt_stall;
    int bad = 0;
    bus_gnt_i = 1'b0;
    send_read(32'h0000_0010);
    for (int i = 0; i < 20; i++) begin
      @(negedge mem_clk);
      if (!bus_req_o || mem_valid_o || mem_addr_o != 32'h0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL gnt_stall: %0d bad cycles, required 0", bad);
    else n_pass++;
    bus_gnt_i = 1'b1;
    @(negedge mem_clk);
    n_checks++;
    if (mem_valid_o !== 1'b1 || mem_read_o !== 1'b1 || mem_addr_o !== 32'h10)
      $display("FAIL gnt_issue: mv=%b rd=%b addr=%08h, required 1/1/00000010", mem_valid_o, mem_read_o, mem_addr_o);
    else n_pass++;
    recv(5, 1'b0);
    n_checks++;
    if ({got[0], got[1], got[2], got[3], got[4]} !== 40'h06DEADBEEF)
      $display("FAIL gnt_data: got %02h%02h%02h%02h%02h, required 06deadbeef", got[0], got[1], got[2], got[3], got[4]);
    else n_pass++;
    $display("read with 20-cycle grant stall done");
  endtask

  task automatic test_back_to_back;
    send_read(32'h0000_0010);
    recv(5, 1'b1);
    n_checks++;
    if ({got[0], got[1], got[2], got[3], got[4]} !== 40'h06DEADBEEF)
      $display("FAIL b2b_data: got %02h%02h%02h%02h%02h, required 06deadbeef", got[0], got[1], got[2], got[3], got[4]);
    else n_pass++;
    @(negedge mem_clk);
    n_checks++;
    if (rx_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL b2b_ready: rdy=%b busy=%b after final handshake, required 1/0", rx_ready_o, busy_o);
    else n_pass++;
    send_read(32'h8000_0080);
    recv(5, 1'b1);
    n_checks++;
    if ({got[0], got[1], got[2], got[3], got[4]} !== 40'h060000005A)
      $display("FAIL b2b_gpio: got %02h%02h%02h%02h%02h, required 060000005a", got[0], got[1], got[2], got[3], got[4]);
    else n_pass++;
    $display("random-ready back-to-back reads done");
  endtask

  task automatic test_wait_limit;
    resp_en = 1'b0;
`ifdef W0RM_DBG_TIMEOUT_EN
    begin
      int txv_k = -1;
      send_read(32'h0000_0010);
      for (int k = 1; k <= 20 && txv_k < 0; k++) begin
        @(negedge mem_clk);
        if (tx_valid_o) txv_k = k;
      end
      n_checks++;
      if (txv_k != 11 || tx_data_o !== 8'h15 || bus_req_o !== 1'b0)
        $display("FAIL timeout: tx at +%0d data=%02h req=%b, required +11/15/0", txv_k, tx_data_o, bus_req_o);
      else n_pass++;
      recv(1, 1'b0);
      late_valid = 1'b1;
      @(negedge mem_clk);
      late_valid = 1'b0;
      @(negedge mem_clk);
      n_checks++;
      if (busy_o !== 1'b0 || tx_valid_o !== 1'b0)
        $display("FAIL late_resp: busy=%b txv=%b, required 0/0", busy_o, tx_valid_o);
      else n_pass++;
      $display("read timeout done");
    end
`else
    send_read(32'h0000_0010);
    repeat (1000) @(negedge mem_clk);
    n_checks++;
    if (busy_o !== 1'b1 || bus_req_o !== 1'b1 || tx_valid_o !== 1'b0)
      $display("FAIL wait_hold: busy=%b req=%b txv=%b, required 1/1/0", busy_o, bus_req_o, tx_valid_o);
    else n_pass++;
    $display("read with no responder held 1000 cycles");
`endif
    resp_en = 1'b1;
  endtask

  task automatic test_async_reset;
    @(negedge mem_clk);
    cpu_reset_n = 1'b0;
    @(negedge mem_clk);
    cpu_reset_n = 1'b1;
    @(negedge mem_clk);
    send_byte(8'h52);
    send_byte(8'h00);
    #2 cpu_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_ready_o, tx_valid_o, bus_req_o, busy_o, mem_valid_o, mem_read_o, mem_write_o} !== 7'b0 ||
        tx_data_o !== 8'h00 || mem_addr_o !== 32'h0)
      $display("FAIL async_reset: rdy/txv/req/busy/mv/rd/wr=%b tx=%02h addr=%08h, required all 0",
               {rx_ready_o, tx_valid_o, bus_req_o, busy_o, mem_valid_o, mem_read_o, mem_write_o}, tx_data_o, mem_addr_o);
    else n_pass++;
    @(negedge mem_clk);
    cpu_reset_n = 1'b1;
    @(negedge mem_clk);
    send_read(32'h0000_0010);
    recv(5, 1'b0);
    n_checks++;
    if ({got[0], got[1], got[2], got[3], got[4]} !== 40'h06DEADBEEF)
      $display("FAIL post_reset: got %02h%02h%02h%02h%02h, required 06deadbeef", got[0], got[1], got[2], got[3], got[4]);
    else n_pass++;
    $display("reset mid-address then read done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    cyc = 0; n_pulse = 0; n_req = 0;
    last_addr = '0; last_data = '0; last_rd = 1'b0; last_wr = 1'b0;
    resp_valid_q = 1'b0; mem_data_i = '0; late_valid = 1'b0;
    resp_en = 1'b1; gpio_pins = 8'h5A;
    rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_ready_i = 1'b0; bus_gnt_i = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_gnt_stall();
    test_back_to_back();
    test_wait_limit();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
